// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals between the datapath and the hazard controller.
// The datapath drives the master side; hazard_ctrl sits on the slave side.
interface hazard_ctrl_if;
  logic        ihit;
  logic        dhit;
  logic        mem_ren;
  logic        mem_wen;
  logic        mem_halt;
  logic        ex_pcsrc;
  logic        idex_dMemREN;
  logic [4:0]  idex_writeReg;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        ifid_use_rt;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        halted;
  logic [15:0] stall_cnt;

  modport master (
    output ihit, dhit, mem_ren, mem_wen, mem_halt, ex_pcsrc,
           idex_dMemREN, idex_writeReg, ifid_rs, ifid_rt, ifid_use_rt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, stall_cnt
  );

  modport slave (
    input  ihit, dhit, mem_ren, mem_wen, mem_halt, ex_pcsrc,
           idex_dMemREN, idex_writeReg, ifid_rs, ifid_rt, ifid_use_rt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, branch flush,
// imem/dmem wait handling, sticky halt and a saturating stall counter.
module hazard_ctrl (
  input  logic          CLK,
  input  logic          nRST,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT, HALTED} state_t;

  state_t      state, next_state;
  logic        halted_r;
  logic [15:0] stall_cnt_r;
  logic        dmem_pend, load_use;
  logic        pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic        ifid_flush_c, idex_flush_c, exmem_flush_c;

  assign dmem_pend = (hz.mem_ren | hz.mem_wen) & ~hz.dhit;

  // The cycle after a load-use stall the bubble is already in EX, so no re-detect.
  assign load_use = hz.idex_dMemREN && (hz.idex_writeReg != 5'd0) &&
                    ((hz.idex_writeReg == hz.ifid_rs) ||
                     (hz.ifid_use_rt && (hz.idex_writeReg == hz.ifid_rt))) &&
                    (state != LD_STALL);

  always_comb begin
    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    idex_en_c     = 1'b1;
    exmem_en_c    = 1'b1;
    memwb_en_c    = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    next_state    = RUN;
    if (!nRST) begin
      {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
      {ifid_flush_c, idex_flush_c, exmem_flush_c}             = '1;
    end else if (state == HALTED) begin
      {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
      next_state = HALTED;
    end else if (hz.mem_halt && !dmem_pend) begin
      {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
      next_state = HALTED;
    end else if (dmem_pend) begin
      // A halt waiting behind an outstanding access freezes here too and retires after dhit.
      {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
      next_state = MEM_WAIT;
    end else if (hz.ex_pcsrc) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
    end else if (load_use) begin
      pc_en_c      = 1'b0;
      ifid_en_c    = 1'b0;
      idex_flush_c = 1'b1;
      next_state   = LD_STALL;
    end else if (!hz.ihit) begin
      pc_en_c      = 1'b0;
      ifid_flush_c = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= RUN;
      halted_r    <= 1'b0;
      stall_cnt_r <= '0;
    end else begin
      state <= next_state;
      if (next_state == HALTED)
        halted_r <= 1'b1;
      if (state != HALTED && !pc_en_c && stall_cnt_r != '1)
        stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end

  assign hz.pc_en       = pc_en_c;
  assign hz.ifid_en     = ifid_en_c;
  assign hz.idex_en     = idex_en_c;
  assign hz.exmem_en    = exmem_en_c;
  assign hz.memwb_en    = memwb_en_c;
  assign hz.ifid_flush  = ifid_flush_c;
  assign hz.idex_flush  = idex_flush_c;
  assign hz.exmem_flush = exmem_flush_c;
  assign hz.halted      = halted_r;
  assign hz.stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a priority-rule model checked every cycle,
// plus literal expectations for each scenario.
module tb_hazard_ctrl;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  hazard_ctrl_if hz();
  hazard_ctrl dut (.CLK(CLK), .nRST(nRST), .hz(hz));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: only halt, "just stalled on load-use" and the stall count matter.
  logic        m_halt  = 1'b0;
  logic        m_ld    = 1'b0;
  logic        m_valid = 1'b0;
  logic [15:0] m_cnt   = '0;

  typedef struct packed {
    logic pc, ifid, idex, exmem, memwb;
    logic f_ifid, f_idex, f_exmem;
    logic go_halt, go_ld;
  } exp_t;

  function automatic exp_t predict();
    exp_t e;
    logic busy, hazard;
    busy   = (hz.mem_ren || hz.mem_wen) && !hz.dhit;
    hazard = hz.idex_dMemREN && hz.idex_writeReg != 5'd0 && !m_ld &&
             (hz.idex_writeReg == hz.ifid_rs ||
              (hz.ifid_use_rt && hz.idex_writeReg == hz.ifid_rt));
    e = '0;
    {e.pc, e.ifid, e.idex, e.exmem, e.memwb} = 5'b11111;
    if (!nRST) begin
      {e.pc, e.ifid, e.idex, e.exmem, e.memwb} = 5'b00000;
      {e.f_ifid, e.f_idex, e.f_exmem} = 3'b111;
    end else if (m_halt || hz.mem_halt || busy) begin
      {e.pc, e.ifid, e.idex, e.exmem, e.memwb} = 5'b00000;
      e.go_halt = m_halt || (hz.mem_halt && !busy);
    end else if (hz.ex_pcsrc) begin
      e.f_ifid = 1'b1;
      e.f_idex = 1'b1;
    end else if (hazard) begin
      e.pc = 1'b0; e.ifid = 1'b0; e.f_idex = 1'b1; e.go_ld = 1'b1;
    end else if (!hz.ihit) begin
      e.pc = 1'b0; e.f_ifid = 1'b1;
    end
    return e;
  endfunction

  always @(posedge CLK) begin
    exp_t e;
    e = predict();
    if (!nRST) begin
      m_halt = 1'b0; m_ld = 1'b0; m_cnt = '0; m_valid = 1'b1;
    end else begin
      if (!m_halt && !e.pc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_halt = m_halt | e.go_halt;
      m_ld   = e.go_ld;
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (m_valid) begin
      e = predict();
      chk("pc_en",       hz.pc_en,       e.pc);
      chk("ifid_en",     hz.ifid_en,     e.ifid);
      chk("idex_en",     hz.idex_en,     e.idex);
      chk("exmem_en",    hz.exmem_en,    e.exmem);
      chk("memwb_en",    hz.memwb_en,    e.memwb);
      chk("ifid_flush",  hz.ifid_flush,  e.f_ifid);
      chk("idex_flush",  hz.idex_flush,  e.f_idex);
      chk("exmem_flush", hz.exmem_flush, e.f_exmem);
      chk("halted",      hz.halted,      m_halt);
      chk("stall_cnt",   hz.stall_cnt,   m_cnt);
    end
  end

  task automatic idle();
    hz.ihit = 1'b1; hz.dhit = 1'b1; hz.mem_ren = 1'b0; hz.mem_wen = 1'b0;
    hz.mem_halt = 1'b0; hz.ex_pcsrc = 1'b0; hz.idex_dMemREN = 1'b0;
    hz.idex_writeReg = 5'd0; hz.ifid_rs = 5'd1; hz.ifid_rt = 5'd2; hz.ifid_use_rt = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle();
    @(negedge CLK);
    chk("rst_pc_en", hz.pc_en, 16'd0);
    chk("rst_exmem_flush", hz.exmem_flush, 16'd1);
    tick();
    chk("rst_halted", hz.halted, 16'd0);
    chk("rst_cnt", hz.stall_cnt, 16'd0);
    nRST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    idle();
    tick();
    do_reset();

    // Load to r5 in EX, ID reads r5: exactly one stall cycle.
    @(negedge CLK); chk("idle_pc_en", hz.pc_en, 16'd1);
    tick();
    hz.idex_dMemREN = 1'b1; hz.idex_writeReg = 5'd5; hz.ifid_rs = 5'd5;
    @(negedge CLK);
    chk("lu_pc_en", hz.pc_en, 16'd0);
    chk("lu_ifid_en", hz.ifid_en, 16'd0);
    chk("lu_idex_flush", hz.idex_flush, 16'd1);
    chk("lu_exmem_en", hz.exmem_en, 16'd1);
    tick();
    @(negedge CLK);
    chk("lu2_pc_en", hz.pc_en, 16'd1);
    chk("lu2_cnt", hz.stall_cnt, 16'd1);
    tick();

    // Load-use through rt, then rt ignored when not used.
    idle(); hz.idex_dMemREN = 1'b1; hz.idex_writeReg = 5'd7; hz.ifid_rt = 5'd7; hz.ifid_use_rt = 1'b1;
    @(negedge CLK); chk("rt_pc_en", hz.pc_en, 16'd0);
    tick();
    idle(); tick();
    hz.idex_dMemREN = 1'b1; hz.idex_writeReg = 5'd2; hz.ifid_rt = 5'd2; hz.ifid_use_rt = 1'b0;
    @(negedge CLK); chk("rt_unused_pc_en", hz.pc_en, 16'd1);
    tick();

    // Load-use with a redirect in the same cycle: flush wins, no stall.
    do_reset();
    hz.idex_dMemREN = 1'b1; hz.idex_writeReg = 5'd5; hz.ifid_rs = 5'd5; hz.ex_pcsrc = 1'b1;
    @(negedge CLK);
    chk("br_pc_en", hz.pc_en, 16'd1);
    chk("br_ifid_en", hz.ifid_en, 16'd1);
    chk("br_ifid_flush", hz.ifid_flush, 16'd1);
    chk("br_idex_flush", hz.idex_flush, 16'd1);
    tick();
    idle();
    @(negedge CLK); chk("br_cnt", hz.stall_cnt, 16'd0);
    tick();

    // Data memory wait for three cycles.
    do_reset();
    hz.mem_ren = 1'b1; hz.dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("dw_pc_en", hz.pc_en, 16'd0);
      chk("dw_memwb_en", hz.memwb_en, 16'd0);
      chk("dw_ifid_flush", hz.ifid_flush, 16'd0);
      tick();
    end
    hz.dhit = 1'b1;
    @(negedge CLK);
    chk("dw_hit_pc_en", hz.pc_en, 16'd1);
    chk("dw_hit_exmem_en", hz.exmem_en, 16'd1);
    tick();
    idle();
    @(negedge CLK); chk("dw_cnt", hz.stall_cnt, 16'd3);
    tick();

    // Load writing r0 never stalls.
    do_reset();
    hz.idex_dMemREN = 1'b1; hz.idex_writeReg = 5'd0; hz.ifid_rs = 5'd0;
    @(negedge CLK);
    chk("r0_pc_en", hz.pc_en, 16'd1);
    chk("r0_idex_flush", hz.idex_flush, 16'd0);
    tick();

    // Instruction miss for two cycles.
    do_reset();
    hz.ihit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("im_pc_en", hz.pc_en, 16'd0);
      chk("im_ifid_flush", hz.ifid_flush, 16'd1);
      chk("im_idex_en", hz.idex_en, 16'd1);
      tick();
    end
    idle();
    @(negedge CLK); chk("im_cnt", hz.stall_cnt, 16'd2);
    tick();

    // Halt is sticky until reset; reset then returns to normal running.
    do_reset();
    hz.mem_halt = 1'b1;
    @(negedge CLK);
    chk("h0_pc_en", hz.pc_en, 16'd0);
    chk("h0_halted", hz.halted, 16'd0);
    tick();
    idle(); hz.ex_pcsrc = 1'b1; hz.ihit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("h_halted", hz.halted, 16'd1);
      chk("h_pc_en", hz.pc_en, 16'd0);
      chk("h_idex_en", hz.idex_en, 16'd0);
      chk("h_ifid_flush", hz.ifid_flush, 16'd0);
      tick();
    end
    nRST = 1'b0;
    @(negedge CLK);
    chk("hr_ifid_flush", hz.ifid_flush, 16'd1);
    chk("hr_halted_pre", hz.halted, 16'd1);
    tick();
    nRST = 1'b1; idle();
    @(negedge CLK);
    chk("hr_halted", hz.halted, 16'd0);
    chk("hr_pc_en", hz.pc_en, 16'd1);
    chk("hr_cnt", hz.stall_cnt, 16'd0);
    tick();

    // Reset while waiting on data memory.
    hz.mem_wen = 1'b1; hz.dhit = 1'b0;
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1; idle();
    @(negedge CLK);
    chk("mwr_pc_en", hz.pc_en, 16'd1);
    chk("mwr_cnt", hz.stall_cnt, 16'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
